hrm_control_unit_v2: RTL and testbench

Parametrised second-generation microcoded control FSM for the HRM CPU. It decodes the instruction register and drives every datapath strobe: IR, register file, memory, AR, ALU, PC, inbox and outbox. It adds the following over the first generation:
- configurable instruction/PC widths
- hardware breakpoint
- IO wait timeout with error reporting
- illegal-opcode trap
- retired-instruction counter

It sits between the IR/flags and the datapath, in the same place as the current control unit.

---
 rtl/hrm_control_unit_v2.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_hrm_control_unit_v2.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hrm_control_unit_v2.sv
// Microcoded control FSM for the HRM CPU. It decodes the IR and drives the datapath strobes.
// Optional macro CU_PERF_EN implements the retired-instruction counter; when it is undefined, retired is tied to 0.
module hrm_control_unit_v2 #(
  parameter int IW      = 8,
  parameter int PCW     = 8,
  parameter int WAIT_TO = 0,
  parameter int TOW     = 16,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            i_rst_n,
  input  logic [IW-1:0]   instr,
  input  logic [PCW-1:0]  pc,
  input  logic [PCW-1:0]  bp_addr,
  input  logic            bp_en,
  input  logic            inEmpty,
  input  logic            outFull,
  input  logic            debug,
  input  logic            nxtInstr,
  output logic            wIR,
  output logic            wR,
  output logic            srcA,
  output logic            wM,
  output logic            wAR,
  output logic            wPC,
  output logic            rIn,
  output logic            wO,
  output logic            ijump,
  output logic            branch,
  output logic [1:0]      muxR,
  output logic [2:0]      aluCtl,
  output logic            rst,
  output logic            halt,
  output logic [1:0]      err,
  output logic [CNTW-1:0] retired,
  output logic [4:0]      state_o
);

  typedef enum logic [4:0] {
    S_RESET     = 5'd0,
    S_FETCH_I   = 5'd1,
    S_WAIT_KEY  = 5'd2,
    S_LOAD_IR   = 5'd3,
    S_DECODE    = 5'd4,
    S_WAIT_IN   = 5'd5,
    S_WAIT_OUT  = 5'd6,
    S_INBOX     = 5'd7,
    S_OUTBOX    = 5'd8,
    S_INCPC2    = 5'd9,
    S_FETCH_O   = 5'd10,
    S_JUMP      = 5'd11,
    S_JUMPZ     = 5'd12,
    S_JUMPN     = 5'd13,
    S_LOAD_AR   = 5'd14,
    S_READMEM2  = 5'd15,
    S_LOAD_AR2  = 5'd16,
    S_READMEM   = 5'd17,
    S_ADD       = 5'd18,
    S_SUB       = 5'd19,
    S_BUMPP     = 5'd20,
    S_BUMPN     = 5'd21,
    S_COPYFROM  = 5'd22,
    S_COPYTO    = 5'd23,
    S_INC_PC    = 5'd24,
    S_HALT      = 5'd25
  } state_t;

  localparam logic [3:0] OP_INBOX    = 4'h0;
  localparam logic [3:0] OP_OUTBOX   = 4'h1;
  localparam logic [3:0] OP_COPYFROM = 4'h2;
  localparam logic [3:0] OP_COPYTO   = 4'h3;
  localparam logic [3:0] OP_ADD      = 4'h4;
  localparam logic [3:0] OP_SUB      = 4'h5;
  localparam logic [3:0] OP_BUMPP    = 4'h6;
  localparam logic [3:0] OP_BUMPN    = 4'h7;
  localparam logic [3:0] OP_JUMP     = 4'h8;
  localparam logic [3:0] OP_JUMPZ    = 4'h9;
  localparam logic [3:0] OP_JUMPN    = 4'hA;
  localparam logic [3:0] OP_HALT     = 4'hF;

  localparam logic [TOW-1:0] TO_LAST = (WAIT_TO > 0) ? TOW'(WAIT_TO - 1) : '0;

  typedef struct packed {
    logic       rst;
    logic       halt;
    logic [2:0] alu;
    logic [1:0] mux;
    logic       branch;
    logic       ijump;
    logic       wo;
    logic       rin;
    logic       wpc;
    logic       war;
    logic       wm;
    logic       srca;
    logic       wr;
    logic       wir;
  } ctl_t;

  state_t         r_state;
  ctl_t           r_ctl;
  logic [1:0]     r_err;
  logic [TOW-1:0] r_to_cnt;

  state_t         w_nxt;
  logic [1:0]     w_err_nxt;
  logic [3:0]     w_op;
  logic           w_ind;
  logic           w_to_hit;
  logic           w_wait_now;
  logic           w_wait_nxt;

  assign w_op  = instr[IW-1:IW-4];
  assign w_ind = instr[IW-5];

  generate
    if (IW > 5) begin : g_unused_operand
      logic w_unused;
      assign w_unused = ^instr[IW-6:0];
    end
  endgenerate

  assign w_wait_now = (r_state == S_WAIT_IN) || (r_state == S_WAIT_OUT);
  assign w_wait_nxt = (w_nxt == S_WAIT_IN) || (w_nxt == S_WAIT_OUT);
  assign w_to_hit   = (WAIT_TO != 0) && (r_to_cnt == TO_LAST);

  // Strobe pattern for each state. It is registered against the next state so that outputs track r_state exactly.
  function automatic ctl_t ctl_decode(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_RESET:    c.rst = 1'b1;
      S_LOAD_IR:  c.wir = 1'b1;
      S_INCPC2:   c.wpc = 1'b1;
      S_INC_PC:   c.wpc = 1'b1;
      S_LOAD_AR:  c.war = 1'b1;
      S_LOAD_AR2: begin
        c.srca = 1'b1;
        c.war  = 1'b1;
      end
      S_JUMP: begin
        c.branch = 1'b1;
        c.wpc    = 1'b1;
        c.ijump  = 1'b1;
      end
      S_JUMPZ: begin
        c.branch = 1'b1;
        c.wpc    = 1'b1;
        c.alu    = 3'b000;
      end
      S_JUMPN: begin
        c.branch = 1'b1;
        c.wpc    = 1'b1;
        c.alu    = 3'b100;
      end
      S_INBOX: begin
        c.rin = 1'b1;
        c.wr  = 1'b1;
        c.mux = 2'b00;
      end
      S_OUTBOX:   c.wo = 1'b1;
      S_COPYTO:   c.wm = 1'b1;
      S_COPYFROM: begin
        c.wr  = 1'b1;
        c.mux = 2'b01;
      end
      S_ADD: begin
        c.wr  = 1'b1;
        c.mux = 2'b11;
        c.alu = 3'b000;
      end
      S_SUB: begin
        c.wr  = 1'b1;
        c.mux = 2'b11;
        c.alu = 3'b001;
      end
      S_BUMPP: begin
        c.wr  = 1'b1;
        c.mux = 2'b11;
        c.alu = 3'b010;
      end
      S_BUMPN: begin
        c.wr  = 1'b1;
        c.mux = 2'b11;
        c.alu = 3'b011;
      end
      S_HALT:     c.halt = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  // Every state that does not explicitly choose a successor falls through to HALT with err=01.
  always_comb begin
    w_nxt     = S_HALT;
    w_err_nxt = 2'b01;
    case (r_state)
      S_RESET:    w_nxt = S_FETCH_I;
      S_FETCH_I:  w_nxt = (debug || (bp_en && (pc == bp_addr))) ? S_WAIT_KEY : S_LOAD_IR;
      S_WAIT_KEY: w_nxt = nxtInstr ? S_LOAD_IR : S_WAIT_KEY;
      S_LOAD_IR:  w_nxt = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_INBOX:  w_nxt = inEmpty ? S_WAIT_IN : S_INBOX;
          OP_OUTBOX: w_nxt = outFull ? S_WAIT_OUT : S_OUTBOX;
          OP_HALT: begin
            w_nxt     = S_HALT;
            w_err_nxt = 2'b00;
          end
          4'hB, 4'hC, 4'hD, 4'hE: begin
            w_nxt     = S_HALT;
            w_err_nxt = 2'b01;
          end
          default:   w_nxt = S_INCPC2;
        endcase
      end
      S_WAIT_IN: begin
        if (!inEmpty) begin
          w_nxt = S_INBOX;
        end else if (w_to_hit) begin
          w_nxt     = S_HALT;
          w_err_nxt = 2'b10;
        end else begin
          w_nxt = S_WAIT_IN;
        end
      end
      S_WAIT_OUT: begin
        if (!outFull) begin
          w_nxt = S_OUTBOX;
        end else if (w_to_hit) begin
          w_nxt     = S_HALT;
          w_err_nxt = 2'b11;
        end else begin
          w_nxt = S_WAIT_OUT;
        end
      end
      S_INCPC2:   w_nxt = S_FETCH_O;
      S_FETCH_O: begin
        case (w_op)
          OP_JUMP:  w_nxt = S_JUMP;
          OP_JUMPZ: w_nxt = S_JUMPZ;
          OP_JUMPN: w_nxt = S_JUMPN;
          default:  w_nxt = S_LOAD_AR;
        endcase
      end
      S_JUMP, S_JUMPZ, S_JUMPN: w_nxt = S_FETCH_I;
      S_LOAD_AR: begin
        if (w_ind)                  w_nxt = S_READMEM2;
        else if (w_op == OP_COPYTO) w_nxt = S_COPYTO;
        else                        w_nxt = S_READMEM;
      end
      S_READMEM2: w_nxt = S_LOAD_AR2;
      S_LOAD_AR2: w_nxt = (w_op == OP_COPYTO) ? S_COPYTO : S_READMEM;
      S_READMEM: begin
        case (w_op)
          OP_ADD:      w_nxt = S_ADD;
          OP_SUB:      w_nxt = S_SUB;
          OP_BUMPP:    w_nxt = S_BUMPP;
          OP_BUMPN:    w_nxt = S_BUMPN;
          OP_COPYFROM: w_nxt = S_COPYFROM;
          default: begin
            w_nxt     = S_HALT;
            w_err_nxt = 2'b01;
          end
        endcase
      end
      S_BUMPP, S_BUMPN: w_nxt = S_COPYTO;
      S_ADD, S_SUB, S_COPYFROM, S_COPYTO, S_INBOX, S_OUTBOX: w_nxt = S_INC_PC;
      S_INC_PC:   w_nxt = S_FETCH_I;
      S_HALT:     w_nxt = S_HALT;
      default: begin
        w_nxt     = S_HALT;
        w_err_nxt = 2'b01;
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_RESET;
      r_ctl    <= ctl_decode(S_RESET);
      r_err    <= 2'b00;
      r_to_cnt <= '0;
    end else begin
      r_state <= w_nxt;
      r_ctl   <= ctl_decode(w_nxt);
      if ((w_nxt == S_HALT) && (r_state != S_HALT)) r_err <= w_err_nxt;
      if (w_wait_nxt && !w_wait_now) r_to_cnt <= '0;
      else if (w_wait_now)           r_to_cnt <= r_to_cnt + TOW'(1);
    end
  end

`ifdef CU_PERF_EN
  logic [CNTW-1:0] r_retired;
  logic            w_retire;

  assign w_retire = (w_nxt == S_FETCH_I) &&
                    ((r_state == S_INC_PC) || (r_state == S_JUMP) ||
                     (r_state == S_JUMPZ)  || (r_state == S_JUMPN));

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + CNTW'(1);
  end

  assign retired = r_retired;
`else
  assign retired = '0;
`endif

  assign wIR     = r_ctl.wir;
  assign wR      = r_ctl.wr;
  assign srcA    = r_ctl.srca;
  assign wM      = r_ctl.wm;
  assign wAR     = r_ctl.war;
  assign wPC     = r_ctl.wpc;
  assign rIn     = r_ctl.rin;
  assign wO      = r_ctl.wo;
  assign ijump   = r_ctl.ijump;
  assign branch  = r_ctl.branch;
  assign muxR    = r_ctl.mux;
  assign aluCtl  = r_ctl.alu;
  assign rst     = r_ctl.rst;
  assign halt    = r_ctl.halt;
  assign err     = r_err;
  assign state_o = r_state;

endmodule

// File: tb/tb_hrm_control_unit_v2.sv
// Directed bench for hrm_control_unit_v2 with WAIT_TO=4; expectations are hand-written state/strobe codes.
module tb_hrm_control_unit_v2;

  localparam logic [4:0] ST_RESET = 5'd0,  ST_FETCH_I = 5'd1,  ST_WAIT_KEY = 5'd2,  ST_LOAD_IR = 5'd3;
  localparam logic [4:0] ST_DECODE = 5'd4, ST_WAIT_IN = 5'd5,  ST_WAIT_OUT = 5'd6,  ST_INBOX = 5'd7;
  localparam logic [4:0] ST_OUTBOX = 5'd8, ST_INCPC2 = 5'd9,   ST_FETCH_O = 5'd10,  ST_JUMP = 5'd11;
  localparam logic [4:0] ST_JUMPZ = 5'd12, ST_JUMPN = 5'd13,   ST_LOAD_AR = 5'd14,  ST_READMEM2 = 5'd15;
  localparam logic [4:0] ST_LOAD_AR2 = 5'd16, ST_READMEM = 5'd17, ST_ADD = 5'd18,   ST_BUMPN = 5'd21;
  localparam logic [4:0] ST_COPYTO = 5'd23, ST_INC_PC = 5'd24,  ST_HALT = 5'd25;

  localparam logic [16:0] C_NONE = 17'h0;
  localparam logic [16:0] C_WIR  = 17'h00001;
  localparam logic [16:0] C_WR   = 17'h00002;
  localparam logic [16:0] C_SRCA = 17'h00004;
  localparam logic [16:0] C_WM   = 17'h00008;
  localparam logic [16:0] C_WAR  = 17'h00010;
  localparam logic [16:0] C_WPC  = 17'h00020;
  localparam logic [16:0] C_RIN  = 17'h00040;
  localparam logic [16:0] C_WO   = 17'h00080;
  localparam logic [16:0] C_IJ   = 17'h00100;
  localparam logic [16:0] C_BR   = 17'h00200;
  localparam logic [16:0] C_MALU = 17'h00C00;
  localparam logic [16:0] C_DEC  = 17'h03000;
  localparam logic [16:0] C_NEG  = 17'h04000;
  localparam logic [16:0] C_HALT = 17'h08000;
  localparam logic [16:0] C_RST  = 17'h10000;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic [7:0]  instr, pc, bp_addr;
  logic        bp_en, inEmpty, outFull, debug, nxtInstr;
  logic        wIR, wR, srcA, wM, wAR, wPC, rIn, wO, ijump, branch, rst, halt;
  logic [1:0]  muxR, err;
  logic [2:0]  aluCtl;
  logic [15:0] retired;
  logic [4:0]  state_o;
  logic [16:0] w_obs;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [15:0] exp_ret;

  always #5 clk = ~clk;

  hrm_control_unit_v2 #(.IW(8), .PCW(8), .WAIT_TO(4), .TOW(16), .CNTW(16)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .instr(instr), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
    .inEmpty(inEmpty), .outFull(outFull), .debug(debug), .nxtInstr(nxtInstr),
    .wIR(wIR), .wR(wR), .srcA(srcA), .wM(wM), .wAR(wAR), .wPC(wPC), .rIn(rIn), .wO(wO),
    .ijump(ijump), .branch(branch), .muxR(muxR), .aluCtl(aluCtl), .rst(rst), .halt(halt),
    .err(err), .retired(retired), .state_o(state_o)
  );

  assign w_obs = {rst, halt, aluCtl, muxR, branch, ijump, wO, rIn, wPC, wAR, wM, srcA, wR, wIR};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [4:0] es, input logic [16:0] ec);
    tick();
    chk({tag, "_state"}, 32'(state_o), 32'(es));
    chk({tag, "_ctl"}, 32'(w_obs), 32'(ec));
  endtask

  task automatic bump_ret();
`ifdef CU_PERF_EN
    exp_ret = exp_ret + 16'd1;
`endif
  endtask

  task automatic do_reset(input string tag);
    i_rst_n = 1'b0;
    #1;
    chk({tag, "_state"}, 32'(state_o), 32'(ST_RESET));
    chk({tag, "_ctl"}, 32'(w_obs), 32'(C_RST));
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_retired"}, 32'(retired), 32'd0);
    exp_ret = '0;
    tick();
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b0; instr = 8'h00; pc = 8'h00; bp_addr = 8'h00; bp_en = 1'b0;
    inEmpty = 1'b0; outFull = 1'b0; debug = 1'b0; nxtInstr = 1'b0; exp_ret = '0;
    tick();
    chk("rst_state", 32'(state_o), 32'(ST_RESET));
    chk("rst_ctl", 32'(w_obs), 32'(C_RST));
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    i_rst_n = 1'b1;

    // INBOX with data available
    step("in_fetch", ST_FETCH_I, C_NONE);
    chk("in_no_count_reset", 32'(retired), 32'd0);
    step("in_ldir", ST_LOAD_IR, C_WIR);
    step("in_dec", ST_DECODE, C_NONE);
    step("in_exec", ST_INBOX, C_RIN | C_WR);
    step("in_incpc", ST_INC_PC, C_WPC);
    step("in_fetch2", ST_FETCH_I, C_NONE);
    bump_ret();
    chk("in_retired", 32'(retired), 32'(exp_ret));

    // indirect COPYTO
    instr = 8'h38;
    step("ct_ldir", ST_LOAD_IR, C_WIR);
    step("ct_dec", ST_DECODE, C_NONE);
    step("ct_incpc2", ST_INCPC2, C_WPC);
    step("ct_fetcho", ST_FETCH_O, C_NONE);
    step("ct_ldar", ST_LOAD_AR, C_WAR);
    step("ct_rdm2", ST_READMEM2, C_NONE);
    step("ct_ldar2", ST_LOAD_AR2, C_SRCA | C_WAR);
    step("ct_copyto", ST_COPYTO, C_WM);
    step("ct_incpc", ST_INC_PC, C_WPC);
    step("ct_fetch", ST_FETCH_I, C_NONE);
    bump_ret();
    chk("ct_retired", 32'(retired), 32'(exp_ret));

    // direct BUMPN goes through READMEM then writes back via COPYTO
    instr = 8'h70;
    step("bn_ldir", ST_LOAD_IR, C_WIR);
    step("bn_dec", ST_DECODE, C_NONE);
    step("bn_incpc2", ST_INCPC2, C_WPC);
    step("bn_fetcho", ST_FETCH_O, C_NONE);
    step("bn_ldar", ST_LOAD_AR, C_WAR);
    step("bn_rdm", ST_READMEM, C_NONE);
    step("bn_exec", ST_BUMPN, C_WR | C_MALU | C_DEC);
    step("bn_copyto", ST_COPYTO, C_WM);
    step("bn_incpc", ST_INC_PC, C_WPC);
    step("bn_fetch", ST_FETCH_I, C_NONE);

    // OUTBOX blocked for the full timeout
    instr = 8'h10; outFull = 1'b1;
    step("ot_ldir", ST_LOAD_IR, C_WIR);
    step("ot_dec", ST_DECODE, C_NONE);
    for (int k = 0; k < 4; k++) step("ot_wait", ST_WAIT_OUT, C_NONE);
    step("ot_halt", ST_HALT, C_HALT);
    chk("ot_err", 32'(err), 32'd3);
    step("ot_halt_hold", ST_HALT, C_HALT);
    chk("ot_err_hold", 32'(err), 32'd3);
    do_reset("ot_reset");

    // OUTBOX unblocks in the last allowed wait cycle
    step("ou_fetch", ST_FETCH_I, C_NONE);
    step("ou_ldir", ST_LOAD_IR, C_WIR);
    step("ou_dec", ST_DECODE, C_NONE);
    for (int k = 0; k < 4; k++) begin
      step("ou_wait", ST_WAIT_OUT, C_NONE);
      if (k == 3) outFull = 1'b0;
    end
    step("ou_exec", ST_OUTBOX, C_WO);
    chk("ou_err", 32'(err), 32'd0);
    step("ou_incpc", ST_INC_PC, C_WPC);
    step("ou_fetch2", ST_FETCH_I, C_NONE);
    bump_ret();
    chk("ou_retired", 32'(retired), 32'(exp_ret));

    // breakpoint at pc 0x05
    instr = 8'h00; bp_en = 1'b1; bp_addr = 8'h05; pc = 8'h05;
    step("bp_stop", ST_WAIT_KEY, C_NONE);
    step("bp_hold", ST_WAIT_KEY, C_NONE);
    nxtInstr = 1'b1;
    step("bp_resume", ST_LOAD_IR, C_WIR);
    nxtInstr = 1'b0;
    step("bp_dec", ST_DECODE, C_NONE);
    step("bp_exec", ST_INBOX, C_RIN | C_WR);
    pc = 8'h06;
    step("bp_incpc", ST_INC_PC, C_WPC);
    step("bp_fetch", ST_FETCH_I, C_NONE);
    step("bp_nostop", ST_LOAD_IR, C_WIR);

    // INBOX blocked for the full timeout
    inEmpty = 1'b1;
    step("it_dec", ST_DECODE, C_NONE);
    for (int k = 0; k < 4; k++) step("it_wait", ST_WAIT_IN, C_NONE);
    step("it_halt", ST_HALT, C_HALT);
    chk("it_err", 32'(err), 32'd2);
    do_reset("it_reset");

    // illegal opcode
    instr = 8'hC0; inEmpty = 1'b0; bp_en = 1'b0;
    step("il_fetch", ST_FETCH_I, C_NONE);
    step("il_ldir", ST_LOAD_IR, C_WIR);
    step("il_dec", ST_DECODE, C_NONE);
    step("il_halt", ST_HALT, C_HALT);
    chk("il_err", 32'(err), 32'd1);
    do_reset("il_reset");

    // ADD, then reset in the middle of a second ADD
    instr = 8'h40;
    step("ad_fetch", ST_FETCH_I, C_NONE);
    step("ad_ldir", ST_LOAD_IR, C_WIR);
    step("ad_dec", ST_DECODE, C_NONE);
    step("ad_incpc2", ST_INCPC2, C_WPC);
    step("ad_fetcho", ST_FETCH_O, C_NONE);
    step("ad_ldar", ST_LOAD_AR, C_WAR);
    step("ad_rdm", ST_READMEM, C_NONE);
    step("ad_exec", ST_ADD, C_WR | C_MALU);
    step("ad_incpc", ST_INC_PC, C_WPC);
    step("ad_fetch2", ST_FETCH_I, C_NONE);
    bump_ret();
    chk("ad_retired", 32'(retired), 32'(exp_ret));
    step("ad2_ldir", ST_LOAD_IR, C_WIR);
    step("ad2_dec", ST_DECODE, C_NONE);
    step("ad2_incpc2", ST_INCPC2, C_WPC);
    step("ad2_fetcho", ST_FETCH_O, C_NONE);
    step("ad2_ldar", ST_LOAD_AR, C_WAR);
    step("ad2_rdm", ST_READMEM, C_NONE);
    step("ad2_exec", ST_ADD, C_WR | C_MALU);
    do_reset("ad_midreset");

    // ten JUMPs, then one JUMPZ and one JUMPN
    instr = 8'h80;
    step("jp_fetch", ST_FETCH_I, C_NONE);
    for (int k = 0; k < 10; k++) begin
      step("jp_ldir", ST_LOAD_IR, C_WIR);
      step("jp_dec", ST_DECODE, C_NONE);
      step("jp_incpc2", ST_INCPC2, C_WPC);
      step("jp_fetcho", ST_FETCH_O, C_NONE);
      step("jp_jump", ST_JUMP, C_BR | C_WPC | C_IJ);
      step("jp_fetch", ST_FETCH_I, C_NONE);
      bump_ret();
    end
`ifdef CU_PERF_EN
    chk("jp_ten_retired", 32'(retired), 32'd10);
`else
    chk("jp_ten_retired", 32'(retired), 32'd0);
`endif
    instr = 8'h90;
    step("jz_ldir", ST_LOAD_IR, C_WIR);
    step("jz_dec", ST_DECODE, C_NONE);
    step("jz_incpc2", ST_INCPC2, C_WPC);
    step("jz_fetcho", ST_FETCH_O, C_NONE);
    step("jz_jump", ST_JUMPZ, C_BR | C_WPC);
    step("jz_fetch", ST_FETCH_I, C_NONE);
    bump_ret();
    instr = 8'hA0;
    step("jn_ldir", ST_LOAD_IR, C_WIR);
    step("jn_dec", ST_DECODE, C_NONE);
    step("jn_incpc2", ST_INCPC2, C_WPC);
    step("jn_fetcho", ST_FETCH_O, C_NONE);
    step("jn_jump", ST_JUMPN, C_BR | C_WPC | C_NEG);
    step("jn_fetch", ST_FETCH_I, C_NONE);
    bump_ret();
    chk("jp_final_retired", 32'(retired), 32'(exp_ret));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
